trx_sequencer: RTL and testbench



---
 rtl/trx_sequencer_pkg.sv | 20 ++
 rtl/trx_level_ramp.sv | 63 ++++++
 rtl/trx_sequencer.sv | 149 ++++++++++++++
 tb/tb_trx_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/trx_sequencer_pkg.sv
// Shared definitions for the TX/RX sequencer: state encodings used for status
// readback and the default timing constants in clock_100k ticks.
package trx_sequencer_pkg;

  typedef enum logic [2:0] {
    SEQ_RX        = 3'd0,
    SEQ_RELAY_ON  = 3'd1,
    SEQ_RAMP_UP   = 3'd2,
    SEQ_TX        = 3'd3,
    SEQ_RAMP_DOWN = 3'd4,
    SEQ_HANG      = 3'd5,
    SEQ_RELAY_OFF = 3'd6
  } seq_state_e;

  localparam int unsigned DEF_RELAY_DELAY = 1000;
  localparam int unsigned DEF_RAMP_DIV    = 16;
  localparam int unsigned DEF_RAMP_STEP   = 4;
  localparam int unsigned DEF_HANG_TIME   = 50000;

endpackage

// File: rtl/trx_level_ramp.sv
// Drive-level ramp: a step divider plus a saturating up/down level register
// that can also track the target directly or be forced to zero.
module trx_level_ramp #(
  parameter int unsigned RAMP_DIV  = 16,
  parameter int unsigned RAMP_STEP = 4
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic       up,
  input  logic       down,
  input  logic       follow,
  input  logic       clear,
  input  logic [7:0] target,
  output logic [7:0] level,
  output logic       at_target,
  output logic       at_zero
);

  localparam int unsigned DIV_W = $clog2(RAMP_DIV) + 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       level_q, level_d;
  logic             div_tc;
  logic [8:0]       level_up;

  assign div_tc   = (div_q == DIV_W'(RAMP_DIV - 1));
  // Nine bits so a step near full scale saturates instead of wrapping.
  assign level_up = {1'b0, level_q} + 9'(RAMP_STEP);

  always_comb begin
    div_d   = div_q;
    level_d = level_q;
    if (clear) begin
      div_d   = '0;
      level_d = '0;
    end else if (follow) begin
      div_d   = '0;
      level_d = target;
    end else if (up || down) begin
      div_d = div_tc ? '0 : div_q + DIV_W'(1);
      if (div_tc && up) begin
        level_d = (level_up > {1'b0, target}) ? target : level_up[7:0];
      end else if (div_tc && down) begin
        level_d = ({1'b0, level_q} < 9'(RAMP_STEP)) ? '0 : level_q - 8'(RAMP_STEP);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      div_q   <= '0;
      level_q <= '0;
    end else begin
      div_q   <= div_d;
      level_q <= level_d;
    end
  end

  assign level     = level_q;
  assign at_target = (level_q == target);
  assign at_zero   = (level_q == '0);

endmodule

// File: rtl/trx_sequencer.sv
// TX/RX sequencer: mutes RX, switches the antenna relay with settle delays and
// ramps the drive level so the relay never switches while the transmitter is hot.
module trx_sequencer
  import trx_sequencer_pkg::*;
#(
  parameter int unsigned RELAY_DELAY = DEF_RELAY_DELAY,
  parameter int unsigned RAMP_DIV    = DEF_RAMP_DIV,
  parameter int unsigned RAMP_STEP   = DEF_RAMP_STEP,
  parameter int unsigned HANG_TIME   = DEF_HANG_TIME
) (
  input  logic       clock_100k,
  input  logic       nreset,
  input  logic       cw_key,
  input  logic       ptt_req,
  input  logic [7:0] tx_level_cfg,
  input  logic       tx_inhibit,
  output logic       rx_mute,
  output logic       relay_tx,
  output logic       tx_enable,
  output logic [7:0] tx_level_out,
  output logic       tx_active,
  output logic [2:0] seq_state
);

  localparam int unsigned MAX_T = (RELAY_DELAY > HANG_TIME) ? RELAY_DELAY : HANG_TIME;
  localparam int unsigned CNT_W = $clog2(MAX_T) + 1;

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             cw_meta_q, cw_s_q;
  logic             cw_mode_q, cw_mode_d;
  logic             rx_mute_q, rx_mute_d;
  logic             relay_tx_q, relay_tx_d;
  logic             tx_enable_q, tx_enable_d;
  logic             tx_active_q, tx_active_d;
  logic             key, abort;
  logic             r_up, r_down, r_follow, r_clear;
  logic             at_target, at_zero;

  assign key = ptt_req | cw_s_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    cw_mode_d = cw_mode_q;
    abort     = 1'b0;
    case (state_q)
      SEQ_RX: begin
        if (key && !tx_inhibit) begin
          state_d   = SEQ_RELAY_ON;
          cw_mode_d = cw_s_q & ~ptt_req;
        end
      end
      SEQ_RELAY_ON: begin
        if (tx_inhibit)                            abort   = 1'b1;
        else if (!key)                             state_d = SEQ_RELAY_OFF;
        else if (cnt_q == CNT_W'(RELAY_DELAY - 1)) state_d = SEQ_RAMP_UP;
        else                                       cnt_d   = cnt_q + CNT_W'(1);
      end
      SEQ_RAMP_UP: begin
        if (tx_inhibit)     abort   = 1'b1;
        else if (!key)      state_d = SEQ_RAMP_DOWN;
        else if (at_target) state_d = SEQ_TX;
      end
      SEQ_TX: begin
        if (tx_inhibit) abort   = 1'b1;
        else if (!key)  state_d = SEQ_RAMP_DOWN;
      end
      SEQ_RAMP_DOWN: begin
        if (tx_inhibit)   abort   = 1'b1;
        else if (key)     state_d = SEQ_RAMP_UP;
        else if (at_zero) state_d = cw_mode_q ? SEQ_HANG : SEQ_RELAY_OFF;
      end
      SEQ_HANG: begin
        if (tx_inhibit) abort = 1'b1;
        else if (key) begin
          state_d   = SEQ_RAMP_UP;
          cw_mode_d = cw_s_q & ~ptt_req;
        end
        else if (cnt_q == CNT_W'(HANG_TIME - 1)) state_d = SEQ_RELAY_OFF;
        else                                     cnt_d   = cnt_q + CNT_W'(1);
      end
      SEQ_RELAY_OFF: begin
        if (cnt_q == CNT_W'(RELAY_DELAY - 1)) state_d = SEQ_RX;
        else                                  cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = SEQ_RX;
    endcase
    if (abort) state_d = SEQ_RELAY_OFF;

    // Ramp operation follows the current state; an abort zeroes the level at once.
    r_up     = (state_q == SEQ_RAMP_UP);
    r_down   = (state_q == SEQ_RAMP_DOWN);
    r_follow = (state_q == SEQ_TX);
    r_clear  = abort || !(r_up || r_down || r_follow);

    rx_mute_d   = (state_d != SEQ_RX);
    relay_tx_d  = state_d inside {SEQ_RELAY_ON, SEQ_RAMP_UP, SEQ_TX, SEQ_RAMP_DOWN, SEQ_HANG};
    tx_enable_d = state_d inside {SEQ_RAMP_UP, SEQ_TX, SEQ_RAMP_DOWN};
    tx_active_d = (state_d == SEQ_TX);
  end

  always_ff @(posedge clock_100k) begin
    if (!nreset) begin
      state_q     <= SEQ_RX;
      cnt_q       <= '0;
      cw_meta_q   <= 1'b0;
      cw_s_q      <= 1'b0;
      cw_mode_q   <= 1'b0;
      rx_mute_q   <= 1'b0;
      relay_tx_q  <= 1'b0;
      tx_enable_q <= 1'b0;
      tx_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cw_meta_q   <= cw_key;
      cw_s_q      <= cw_meta_q;
      cw_mode_q   <= cw_mode_d;
      rx_mute_q   <= rx_mute_d;
      relay_tx_q  <= relay_tx_d;
      tx_enable_q <= tx_enable_d;
      tx_active_q <= tx_active_d;
    end
  end

  trx_level_ramp #(
    .RAMP_DIV  (RAMP_DIV),
    .RAMP_STEP (RAMP_STEP)
  ) u_ramp (
    .clk       (clock_100k),
    .nreset    (nreset),
    .up        (r_up),
    .down      (r_down),
    .follow    (r_follow),
    .clear     (r_clear),
    .target    (tx_level_cfg),
    .level     (tx_level_out),
    .at_target (at_target),
    .at_zero   (at_zero)
  );

  assign rx_mute   = rx_mute_q;
  assign relay_tx  = relay_tx_q;
  assign tx_enable = tx_enable_q;
  assign tx_active = tx_active_q;
  assign seq_state = state_q;

endmodule

// File: tb/tb_trx_sequencer.sv
// Directed bench for trx_sequencer: reset, PTT and CW cycles, abort, level
// boundaries and mid-sequence events, with hand-computed expectations.
module tb_trx_sequencer;

  localparam int RD = 1000;
  localparam int HT = 3000;

  logic       clk = 1'b0;
  logic       nreset, cw_key, ptt_req, tx_inhibit;
  logic [7:0] tx_level_cfg;
  logic       rx_mute, relay_tx, tx_enable, tx_active;
  logic [7:0] tx_level_out;
  logic [2:0] seq_state;

  int n_vec = 0;
  int n_bad = 0;
  int n;

  always #5 clk = ~clk;

  trx_sequencer #(
    .RELAY_DELAY (RD),
    .RAMP_DIV    (16),
    .RAMP_STEP   (4),
    .HANG_TIME   (HT)
  ) dut (
    .clock_100k   (clk),
    .nreset       (nreset),
    .cw_key       (cw_key),
    .ptt_req      (ptt_req),
    .tx_level_cfg (tx_level_cfg),
    .tx_inhibit   (tx_inhibit),
    .rx_mute      (rx_mute),
    .relay_tx     (relay_tx),
    .tx_enable    (tx_enable),
    .tx_level_out (tx_level_out),
    .tx_active    (tx_active),
    .seq_state    (seq_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until seq_state (sel=0) or tx_level_out (sel=1) equals val; n=-1 on timeout.
  task automatic wait_for(input int sel, input int val, input int max, output int cnt);
    cnt = -1;
    for (int i = 1; i <= max; i++) begin
      tick();
      if ((sel == 0 && int'(seq_state) == val) || (sel == 1 && int'(tx_level_out) == val)) begin
        cnt = i;
        break;
      end
    end
  endtask

  function automatic logic [31:0] outs();
    return {19'd0, rx_mute, relay_tx, tx_enable, tx_active, seq_state, tx_level_out};
  endfunction

  initial begin
    nreset = 1'b0; cw_key = 1'b0; ptt_req = 1'b1; tx_inhibit = 1'b0; tx_level_cfg = 8'd40;

    // 1. reset with PTT held, then release
    repeat (3) tick();
    check("reset_outs", outs(), 32'd0);
    nreset = 1'b1;
    tick();
    check("rel_relay_mute", {relay_tx, rx_mute, seq_state}, {1'b1, 1'b1, 3'd1});

    // 2. PTT cycle, cfg 40
    wait_for(0, 2, 2*RD, n);
    check("relay_to_enable", n, RD);
    check("enable_at_rampup", tx_enable, 1);
    wait_for(1, 40, 400, n);
    check("ramp_up_ticks", n, 160);
    tick();
    check("tx_reached", {tx_active, seq_state, tx_level_out}, {1'b1, 3'd3, 8'd40});
    ptt_req = 1'b0;
    tick();
    check("ramp_down_entry", seq_state, 4);
    wait_for(1, 0, 400, n);
    check("ramp_down_ticks", n, 160);
    tick();
    check("relay_off", {relay_tx, rx_mute, tx_enable, seq_state}, {1'b0, 1'b1, 1'b0, 3'd6});
    wait_for(0, 0, 2*RD, n);
    check("relay_off_ticks", n, RD);
    check("rx_unmuted", rx_mute, 0);

    // 3. CW keying with hang and rekey
    cw_key = 1'b1;
    wait_for(0, 3, 2000, n);
    check("cw_tx", seq_state, 3);
    cw_key = 1'b0;
    wait_for(0, 5, 500, n);
    check("hang_outs", {relay_tx, tx_enable, rx_mute, seq_state}, {1'b1, 1'b0, 1'b1, 3'd5});
    repeat (1000) tick();
    check("hang_held", seq_state, 5);
    cw_key = 1'b1;
    wait_for(0, 2, 10, n);
    check("rekey_latency", n, 3);
    check("rekey_relay_kept", relay_tx, 1);
    wait_for(0, 3, 400, n);
    cw_key = 1'b0;
    wait_for(0, 5, 500, n);
    check("hang2_entry", seq_state, 5);
    wait_for(0, 6, HT + 100, n);
    check("hang_time", n, HT);
    wait_for(0, 0, 2*RD, n);
    check("cw_back_rx", seq_state, 0);

    // 4. abort from TX at level 200, then inhibit blocks entry
    tx_level_cfg = 8'd200;
    ptt_req = 1'b1;
    wait_for(0, 3, 3000, n);
    check("tx_level_200", tx_level_out, 200);
    tx_inhibit = 1'b1;
    tick();
    tx_inhibit = 1'b0;
    check("abort", {tx_level_out, tx_enable, relay_tx, seq_state}, {8'd0, 1'b0, 1'b0, 3'd6});
    ptt_req = 1'b0;
    wait_for(0, 0, 2*RD, n);
    tx_inhibit = 1'b1;
    ptt_req = 1'b1;
    repeat (5) tick();
    check("inhibit_blocks_rx", {seq_state, rx_mute, relay_tx}, {3'd0, 1'b0, 1'b0});
    tx_inhibit = 1'b0;
    ptt_req = 1'b0;
    tick();

    // 5. boundaries: cfg 0, cfg 255 saturation, live cfg change in TX
    tx_level_cfg = 8'd0;
    ptt_req = 1'b1;
    wait_for(0, 2, 2*RD, n);
    tick();
    check("cfg0_tx_first_tick", {seq_state, tx_level_out}, {3'd3, 8'd0});
    ptt_req = 1'b0;
    wait_for(0, 0, 2*RD + 10, n);
    tx_level_cfg = 8'd255;
    ptt_req = 1'b1;
    wait_for(0, 3, 3000, n);
    check("sat_255", {tx_active, tx_level_out}, {1'b1, 8'd255});
    tx_level_cfg = 8'd200;
    tick();
    check("cfg_200", tx_level_out, 200);
    tx_level_cfg = 8'd100;
    tick();
    check("cfg_100_next_tick", tx_level_out, 100);
    ptt_req = 1'b0;
    wait_for(0, 0, 2*RD + 500, n);

    // 6. drop PTT mid RELAY_ON; reset during RAMP_UP
    ptt_req = 1'b1;
    wait_for(0, 1, 10, n);
    repeat (500) tick();
    ptt_req = 1'b0;
    tick();
    check("drop_relay_on", {seq_state, tx_level_out, relay_tx}, {3'd6, 8'd0, 1'b0});
    wait_for(0, 0, 2*RD, n);
    ptt_req = 1'b1;
    wait_for(0, 2, 2*RD, n);
    repeat (20) tick();
    check("ramp_mid_level", tx_level_out, 4);
    nreset = 1'b0;
    tick();
    check("reset_mid_ramp", outs(), 32'd0);
    ptt_req = 1'b0;
    nreset = 1'b1;
    tick();
    check("after_reset_rx", seq_state, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
